// File: rtl/branch_pkg.sv
// Shared types for the branch controller: funct3 codes, FSM states, predictor counters.
// Counter helper saturates at SNT/ST so callers never wrap.
package branch_pkg;

  typedef logic [2:0] funct3_t;

  localparam funct3_t F3_BEQ  = 3'b000;
  localparam funct3_t F3_BNE  = 3'b001;
  localparam funct3_t F3_BLT  = 3'b100;
  localparam funct3_t F3_BGE  = 3'b101;
  localparam funct3_t F3_BLTU = 3'b110;
  localparam funct3_t F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Request, comparator and response signals of the branch controller.
// slave = controller side, master = pipeline/comparator side.
interface branch_ctrl_if
  import branch_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  funct3_t         req_funct3;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_imm;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            pred_taken;
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;
  logic            cmp_brun;
  logic            cmp_breq;
  logic            cmp_brlt;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_taken;
  logic [XLEN-1:0] rsp_target;
  logic            rsp_mispredict;
  logic            rsp_illegal;

  modport slave (
    input  req_valid, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
    input  cmp_breq, cmp_brlt, rsp_ready,
    output req_ready, pred_taken, cmp_a, cmp_b, cmp_brun,
    output rsp_valid, rsp_taken, rsp_target, rsp_mispredict, rsp_illegal
  );

  modport master (
    output req_valid, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
    output cmp_breq, cmp_brlt, rsp_ready,
    input  req_ready, pred_taken, cmp_a, cmp_b, cmp_brun,
    input  rsp_valid, rsp_taken, rsp_target, rsp_mispredict, rsp_illegal
  );

endinterface

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters, reset to weakly not-taken.
// Combinational read; a same-cycle update is visible only from the next cycle.
module branch_bht
  import branch_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDXW    = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDXW-1:0] rd_idx_i,
  output ctr_t            rd_ctr_o,
  input  logic            upd_en_i,
  input  logic [IDXW-1:0] upd_idx_i,
  input  logic            upd_taken_i
);

  ctr_t ctr_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

  assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_ctrl.sv
// Conditional-branch sequencer: IDLE accepts, CMP drives the comparator, RESP holds the result.
// Response valid two cycles after acceptance; held until rsp_ready; one branch per three cycles.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  branch_ctrl_if.slave bus
);

  localparam int IDXW = $clog2(BHT_ENTRIES);

  state_t          state_q, state_d;
  funct3_t         funct3_q, funct3_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            pred_q, pred_d;
  logic [XLEN-1:0] cmp_a_q, cmp_a_d;
  logic [XLEN-1:0] cmp_b_q, cmp_b_d;
  logic            brun_q, brun_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            mispred_q, mispred_d;
  logic            illegal_q, illegal_d;

  ctr_t rd_ctr;
  logic in_cmp, accept, handshake, upd_en;
  logic eq, lt, brun_now, taken_now, illegal_now;

  assign in_cmp    = (state_q == CMP);
  assign accept    = (state_q == IDLE) && bus.req_valid && !flush;
  assign handshake = (state_q == RESP) && bus.rsp_ready && !flush;
  assign upd_en    = handshake && !illegal_q;

  assign brun_now = (funct3_q == F3_BLTU) || (funct3_q == F3_BGEU);
  // Equality dominates: a comparator reporting both eq and lt is treated as not-less-than.
  assign eq = bus.cmp_breq;
  assign lt = bus.cmp_brlt && !bus.cmp_breq;

  always_comb begin
    taken_now   = 1'b0;
    illegal_now = 1'b0;
    case (funct3_q)
      F3_BEQ:           taken_now = eq;
      F3_BNE:           taken_now = !eq;
      F3_BLT, F3_BLTU:  taken_now = lt;
      F3_BGE, F3_BGEU:  taken_now = !lt;
      default:          illegal_now = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.req_valid) state_d = CMP;
        CMP:     state_d = RESP;
        RESP:    if (bus.rsp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    funct3_d  = funct3_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    pred_d    = pred_q;
    cmp_a_d   = cmp_a_q;
    cmp_b_d   = cmp_b_q;
    brun_d    = brun_q;
    taken_d   = taken_q;
    target_d  = target_q;
    mispred_d = mispred_q;
    illegal_d = illegal_q;
    if (accept) begin
      funct3_d = bus.req_funct3;
      pc_d     = bus.req_pc;
      imm_d    = bus.req_imm;
      rs1_d    = bus.req_rs1;
      rs2_d    = bus.req_rs2;
      pred_d   = rd_ctr[1];
    end
    if (in_cmp) begin
      cmp_a_d = rs1_q;
      cmp_b_d = rs2_q;
      brun_d  = brun_now;
      if (!flush) begin
        taken_d   = taken_now;
        target_d  = pc_q + imm_q;
        mispred_d = !illegal_now && (taken_now != pred_q);
        illegal_d = illegal_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_d_reset: begin
        funct3_q  <= '0;
        pc_q      <= '0;
        imm_q     <= '0;
        rs1_q     <= '0;
        rs2_q     <= '0;
        pred_q    <= 1'b0;
        cmp_a_q   <= '0;
        cmp_b_q   <= '0;
        brun_q    <= 1'b0;
        taken_q   <= 1'b0;
        target_q  <= '0;
        mispred_q <= 1'b0;
        illegal_q <= 1'b0;
      end
    end else begin
      funct3_q  <= funct3_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      pred_q    <= pred_d;
      cmp_a_q   <= cmp_a_d;
      cmp_b_q   <= cmp_b_d;
      brun_q    <= brun_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      mispred_q <= mispred_d;
      illegal_q <= illegal_d;
    end
  end

  branch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (bus.req_pc[IDXW+1:2]),
    .rd_ctr_o    (rd_ctr),
    .upd_en_i    (upd_en),
    .upd_idx_i   (pc_q[IDXW+1:2]),
    .upd_taken_i (taken_q)
  );

  // Comparator inputs follow the operands during CMP and otherwise hold the last driven value.
  assign bus.cmp_a    = in_cmp ? rs1_q    : cmp_a_q;
  assign bus.cmp_b    = in_cmp ? rs2_q    : cmp_b_q;
  assign bus.cmp_brun = in_cmp ? brun_now : brun_q;

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.pred_taken     = rd_ctr[1];
  assign bus.rsp_valid      = (state_q == RESP);
  assign bus.rsp_taken      = taken_q;
  assign bus.rsp_target     = target_q;
  assign bus.rsp_mispredict = mispred_q;
  assign bus.rsp_illegal    = illegal_q;

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Sequencing controller for the branch comparator in the RV32I core. Accepts one conditional-branch request at a time, drives the comparator operands and BrUn, samples BrEq/BrLT, and evaluates the funct3 condition. Computes the branch target, returns a taken/target response over a valid/ready handshake, and keeps a small table of 2-bit saturating counters that supplies a taken prediction and flags mispredicts.

Parameters:
XLEN, 32, operand/PC width
BHT_ENTRIES, 16, predictor counters, power of two >= 2; index = pc[log2(BHT_ENTRIES)+1:2]

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
flush  input  1  synchronous abort of in-flight branch
req_valid  input  1  branch request valid
req_ready  output  1  controller can accept request
req_funct3  input  3  branch funct3
req_pc  input  XLEN  branch instruction PC
req_imm  input  XLEN  sign-extended B-immediate
req_rs1  input  XLEN  rs1 value
req_rs2  input  XLEN  rs2 value
pred_taken  output  1  BHT prediction for req_pc (combinational)
cmp_a  output  XLEN  to comparator A_bus
cmp_b  output  XLEN  to comparator B_bus
cmp_brun  output  1  to comparator BrUn
cmp_breq  input  1  from comparator BrEq
cmp_brlt  input  1  from comparator BrLT
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_taken  output  1  branch resolved taken
rsp_target  output  XLEN  req_pc + req_imm
rsp_mispredict  output  1  rsp_taken != prediction made at acceptance
rsp_illegal  output  1  funct3 is 010 or 011

Behaviour:
- States: IDLE, CMP, RESP. Reset -> IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_taken=0, rsp_target=0, rsp_mispredict=0, rsp_illegal=0, cmp_a=0, cmp_b=0, cmp_brun=0. All BHT counters = 2'b01 (weakly not-taken).
- IDLE:
  - req_ready=1.
  - On req_valid: register funct3, pc, imm, rs1, rs2, and pred_taken. Go to CMP.
- CMP (one cycle):
  - cmp_a=rs1_q, cmp_b=rs2_q, cmp_brun=1 iff funct3_q is 110 or 111.
  - Sample cmp_breq/cmp_brlt at the clock edge. If cmp_breq=1, lt is forced to 0.
  - Register taken, target, mispredict, illegal. Go to RESP.
- Condition evaluation:
  - 000: eq
  - 001: !eq
  - 100 and 110: lt
  - 101 and 111: !lt
  - 010 and 011: illegal, taken=0, mispredict=0
- cmp_brlt contract: signed compare when cmp_brun=0, unsigned when 1.
- Outside CMP, cmp_a, cmp_b and cmp_brun hold their last values. Comparator outputs are ignored outside CMP.
- Target: rsp_target = pc_q + imm_q, modulo 2^XLEN (wrap, no overflow flag). Computed even when not taken.
- RESP:
  - rsp_valid=1; response fields held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: update BHT[idx(pc_q)] (taken: +1 saturating at 11; not-taken: -1 saturating at 00; illegal: no update). Go to IDLE.
- Latency: response valid 2 cycles after acceptance. Back-to-back throughput: one branch per 3 cycles with rsp_ready held high.
- pred_taken = BHT[idx(req_pc)][1], combinational, valid in every state. It is registered only at acceptance.
- BHT write/read collision: a lookup in the same cycle as an update returns the pre-update value. Not reachable today, since req is only accepted in IDLE, but it is defined this way.
- flush:
  - Any state -> IDLE next cycle; rsp_valid=0 next cycle; no BHT update.
  - Flush wins over a simultaneous rsp handshake; that response is treated as not consumed.
  - flush in IDLE with req_valid: the request is not accepted.
- rst_n low mid-operation: immediate return to IDLE, all outputs and BHT to reset values. No partial update.

Decomposition:
- Shared package branch_pkg:
  - funct3 constants F3_BEQ/BNE/BLT/BGE/BLTU/BGEU
  - state enum typedef {IDLE, CMP, RESP}
  - 2-bit counter typedef with constants SNT=00, WNT=01, WT=10, ST=11
- One sub-module, branch_bht: BHT_ENTRIES x 2-bit counter array with async reset, combinational read port, and a saturating update port (en, idx, taken).
- FSM, condition logic and target adder stay in branch_ctrl.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, rsp_ready=1: rsp_valid 2 cycles after accept, taken=1, target=0x120, mispredict=1 (reset prediction not-taken). BHT[0] becomes 10.
- BLT vs BLTU, rs1=0xFFFFFFFF, rs2=1: BLT gives taken=1 with cmp_brun=0; BLTU gives taken=0 with cmp_brun=1.
- BGE, rs1=rs2=7: BrEq priority gives lt=0, so taken=1. Same operands with BNE give taken=0.
- Same pc (0x40), taken 3 times: pred_taken goes 0,1,1 and the counter saturates at 11. Next not-taken gives mispredict=1 and counter=10.
- rsp_ready low for 4 cycles in RESP: rsp_valid and all fields stable, req_ready=0. Assert flush in cycle 3: next cycle IDLE, rsp_valid=0, BHT unchanged.
- funct3=010: rsp_illegal=1, taken=0, mispredict=0, no BHT change. Separately, pc=0xFFFFFFF0, imm=0x20 gives target=0x10. rst_n pulse during CMP: IDLE, outputs zero, BHT all 01.
